// File: rtl/twoinput_rr_arbiter.sv
// Two-input round-robin arbiter feeding a single registered output beat; 1-cycle input-to-output latency.
// Backpressure: a held beat with Z_ready low stalls both sources; drain and reload in the same cycle keeps 1 beat/cycle.
module twoinput_rr_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         A_valid,
  input  logic [W-1:0] A_data,
  output logic         A_ready,
  input  logic         B_valid,
  input  logic [W-1:0] B_data,
  output logic         B_ready,
  output logic         S,
  output logic         Z_valid,
  output logic [W-1:0] Z_data,
  input  logic         Z_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  state_t         state_q, state_d;
  logic [W-1:0]   z_data_q, z_data_d;
  logic           s_q, s_d;
  logic           last_q, last_d;

  logic           load_en;
  logic           grant_a;
  logic           grant_b;
  logic           acc_a;
  logic           acc_b;

  // On a tie the source that did not win last time takes the grant.
  always_comb begin
    load_en = (state_q == EMPTY) | Z_ready;
    grant_a = A_valid & (~B_valid | (last_q == SRC_B));
    grant_b = B_valid & (~A_valid | (last_q == SRC_A));
    acc_a   = load_en & grant_a & ~rst;
    acc_b   = load_en & grant_b & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      z_data_q <= '0;
      s_q      <= 1'b0;
      last_q   <= SRC_B;
    end else begin
      state_q  <= state_d;
      z_data_q <= z_data_d;
      s_q      <= s_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (acc_a | acc_b) state_d = FULL;
      end
      FULL: begin
        if (!(acc_a | acc_b) && Z_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Payload, select and round-robin pointer move only on an accepted beat.
  always_comb begin
    z_data_d = z_data_q;
    s_d      = s_q;
    last_d   = last_q;
    if (acc_a) begin
      z_data_d = A_data;
      s_d      = 1'b0;
      last_d   = SRC_A;
    end else if (acc_b) begin
      z_data_d = B_data;
      s_d      = 1'b1;
      last_d   = SRC_B;
    end
  end

  always_comb begin
    A_ready = acc_a;
    B_ready = acc_b;
    Z_valid = (state_q == FULL);
    Z_data  = z_data_q;
    S       = s_q;
  end

endmodule

// File: tb/tb_twoinput_rr_arbiter.sv
// Bench for twoinput_rr_arbiter: directed scenarios plus a randomized run against a queue-based reference.
module tb_twoinput_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, z_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, s_out, z_valid;
  logic [W-1:0] z_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  twoinput_rr_arbiter #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .A_valid (a_valid),
    .A_data  (a_data),
    .A_ready (a_ready),
    .B_valid (b_valid),
    .B_data  (b_data),
    .B_ready (b_ready),
    .S       (s_out),
    .Z_valid (z_valid),
    .Z_data  (z_data),
    .Z_ready (z_ready)
  );

  // Apply inputs mid-cycle, then settle before the caller samples.
  task automatic drive(input logic r, input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd, input logic zr);
    @(negedge clk);
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; z_ready = zr;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: A_ready=%b B_ready=%b required 0 0", a_ready, b_ready);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (z_valid !== 1'b0 || z_data !== 8'h00 || s_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Z_valid=%b Z_data=%h S=%b required 0 00 0", z_valid, z_data, s_out);
    end
  endtask

  task automatic test_alternate();
    logic [W-1:0] exp_d [4];
    logic         exp_s [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;
    exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;  exp_s[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i < 4, 8'h11, i < 4, 8'h22, 1'b1);
      if (i < 4) begin
        checks++;
        if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
          errors++;
          $display("FAIL alt_grant[%0d]: A_ready=%b B_ready=%b required %b %b",
                   i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
        end
      end
      if (i > 0) begin
        checks++;
        if (z_valid !== 1'b1 || z_data !== exp_d[i-1] || s_out !== exp_s[i-1]) begin
          errors++;
          $display("FAIL alt_out[%0d]: Z_valid=%b Z_data=%h S=%b required 1 %h %b",
                   i - 1, z_valid, z_data, s_out, exp_d[i-1], exp_s[i-1]);
        end
      end
    end
  endtask

  task automatic test_only_b();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 8'h00, i < 3, 8'h5A, 1'b1);
      if (i < 3) begin
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
          errors++;
          $display("FAIL onlyb_grant[%0d]: A_ready=%b B_ready=%b required 0 1", i, a_ready, b_ready);
        end
      end
      if (i > 0) begin
        checks++;
        if (z_valid !== 1'b1 || z_data !== 8'h5A || s_out !== 1'b1) begin
          errors++;
          $display("FAIL onlyb_out[%0d]: Z_valid=%b Z_data=%h S=%b required 1 5a 1", i, z_valid, z_data, s_out);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h99, 1'b1, 8'h44, 1'b0);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || z_valid !== 1'b1 || z_data !== 8'h33 || s_out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: A_ready=%b B_ready=%b Z_valid=%b Z_data=%h S=%b required 0 0 1 33 0",
                 i, a_ready, b_ready, z_valid, z_data, s_out);
      end
    end
    drive(1'b0, 1'b1, 8'h99, 1'b1, 8'h44, 1'b1);
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: A_ready=%b B_ready=%b required 0 1", a_ready, b_ready);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (z_valid !== 1'b1 || z_data !== 8'h44 || s_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_after: Z_valid=%b Z_data=%h S=%b required 1 44 1", z_valid, z_data, s_out);
    end
  endtask

  task automatic test_drain_no_grant();
    drive(1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checks++;
    if (z_valid !== 1'b0 || z_data !== 8'h55 || s_out !== 1'b0) begin
      errors++;
      $display("FAIL drain: Z_valid=%b Z_data=%h S=%b required 0 55 0", z_valid, z_data, s_out);
    end
    drive(1'b0, 1'b1, 8'h01, 1'b1, 8'h02, 1'b1);
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_last: A_ready=%b B_ready=%b required 0 1", a_ready, b_ready);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8'h66, 1'b1, 8'h88, 1'b0);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready: A_ready=%b B_ready=%b required 0 0", a_ready, b_ready);
    end
    drive(1'b0, 1'b1, 8'h66, 1'b1, 8'h88, 1'b0);
    checks++;
    if (z_valid !== 1'b0 || z_data !== 8'h00 || s_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: Z_valid=%b Z_data=%h S=%b required 0 00 0", z_valid, z_data, s_out);
    end
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_tie: A_ready=%b B_ready=%b required 1 0", a_ready, b_ready);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  // Reference: holding register as a queue of at most one beat, winner by "not the last winner".
  task automatic test_random();
    logic [W:0]   held [$];
    logic [W:0]   sb   [$];
    logic [W:0]   got;
    int           last_src;
    logic         av, bv, zr, ea, eb, can_load;
    logic [W-1:0] ad, bd;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    last_src = 1;
    for (int c = 0; c < 10000; c++) begin
      av = ($urandom_range(0, 99) < 60);
      bv = ($urandom_range(0, 99) < 60);
      zr = ($urandom_range(0, 99) < 70);
      ad = W'($urandom);
      bd = W'($urandom);
      drive(1'b0, av, ad, bv, bd, zr);
      can_load = (held.size() == 0) || zr;
      ea = can_load && av && (!bv || last_src == 1);
      eb = can_load && bv && (!av || last_src == 0);
      checks++;
      if (a_ready !== ea || b_ready !== eb || z_valid !== (held.size() != 0)) begin
        errors++;
        $display("FAIL rand_ctl[%0d]: A_ready=%b B_ready=%b Z_valid=%b required %b %b %b",
                 c, a_ready, b_ready, z_valid, ea, eb, (held.size() != 0));
      end
      if (z_valid === 1'b1 && zr) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_dup[%0d]: output beat %h with no accepted input pending", c, z_data);
        end else begin
          got = sb.pop_front();
          if ({s_out, z_data} !== got) begin
            errors++;
            $display("FAIL rand_data[%0d]: S=%b Z_data=%h required %b %h", c, s_out, z_data, got[W], got[W-1:0]);
          end
        end
      end
      if (a_ready === 1'b1 && av) sb.push_back({1'b0, ad});
      if (b_ready === 1'b1 && bv) sb.push_back({1'b1, bd});
      if (held.size() != 0 && zr) void'(held.pop_front());
      if (ea) begin held.push_back({1'b0, ad}); last_src = 0; end
      if (eb) begin held.push_back({1'b1, bd}); last_src = 1; end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    if (z_valid === 1'b1) void'(sb.pop_front());
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checks++;
    if (sb.size() != 0 || z_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_lost: pending=%0d Z_valid=%b required 0 0", sb.size(), z_valid);
    end
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; z_ready = 1'b0;
    a_data = '0; b_data = '0;
    test_reset();
    test_alternate();
    test_only_b();
    test_backpressure();
    test_drain_no_grant();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
